// File: rtl/game_turn_controller.sv
// rtl/game_turn_controller.sv - two-player basketball turn sequencer
//
// Purpose: alternates player turns, runs a per-turn shot clock and shot limit,
// turns raw shot buttons into single-cycle strobes for the scoring datapath,
// and freezes play once the datapath reports a winner.
//
// Ports:
//   CLK, RST                     clock, asynchronous active-high reset
//   start                        raw button: start / restart after game over
//   btn_one/btn_two/btn_three    raw shot buttons
//   win_p1/win_p2                winner flags from the scoring datapath (level)
//   mode                         active player (0 = P1, 1 = P2)
//   shot_one/two/three           one-cycle shot strobes
//   shot_timer                   ticks left in the turn (or in the switch gap)
//   shots_left                   shots left in the turn
//   state_code                   IDLE=0 P1_TURN=1 SWITCH=2 P2_TURN=3 GAME_OVER=4
//   winner                       00 none, 01 P1, 10 P2
module game_turn_controller #(
  parameter int TICK_DIV       = 10_000_000,
  parameter int SHOT_TIME      = 50,
  parameter int SHOTS_PER_TURN = 3,
  parameter int SWITCH_TICKS   = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       btn_one,
  input  logic       btn_two,
  input  logic       btn_three,
  input  logic       win_p1,
  input  logic       win_p2,
  output logic       mode,
  output logic       shot_one,
  output logic       shot_two,
  output logic       shot_three,
  output logic [7:0] shot_timer,
  output logic [3:0] shots_left,
  output logic [2:0] state_code,
  output logic [1:0] winner
);

  localparam int TW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_P1     = 3'd1,
    S_SWITCH = 3'd2,
    S_P2     = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [7:0]    timer_q, timer_d;
  logic [3:0]    shots_q, shots_d;
  logic [1:0]    winner_q, winner_d;
  logic [2:0]    strobe_q, strobe_d;   // {three, two, one}
  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  // Button bit order: {three, two, one, start}
  logic [3:0] raw;
  logic [3:0] sync1_q, sync2_q, prev_q, edge_q;

  logic [7:0] timer_dec;
  logic [3:0] shots_dec;

  assign raw  = {btn_three, btn_two, btn_one, start};
  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  // Edge is registered so the FSM sees it one cycle after sync2 goes high;
  // the strobe register then adds one more cycle (3 CLK from first sample).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      edge_q     <= '0;
      tick_cnt_q <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      edge_q     <= sync2_q & ~prev_q;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      timer_q  <= '0;
      shots_q  <= '0;
      winner_q <= 2'b00;
      strobe_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      timer_q  <= timer_d;
      shots_q  <= shots_d;
      winner_q <= winner_d;
      strobe_q <= strobe_d;
    end
  end

  // Saturating decrements
  assign timer_dec = (timer_q != 8'd0) ? timer_q - 8'd1 : 8'd0;
  assign shots_dec = (shots_q != 4'd0) ? shots_q - 4'd1 : 4'd0;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    timer_d  = timer_q;
    shots_d  = shots_q;
    winner_d = winner_q;
    strobe_d = 3'b000;

    case (state_q)
      S_IDLE: begin
        if (edge_q[0]) begin
          state_d = S_P1;
          mode_d  = 1'b0;
          timer_d = 8'(SHOT_TIME);
          shots_d = 4'(SHOTS_PER_TURN);
        end
      end

      S_P1, S_P2: begin
        if (win_p1 || win_p2) begin
          state_d  = S_OVER;
          winner_d = win_p1 ? 2'b01 : 2'b10;
        end else begin
          if (edge_q[3])      strobe_d = 3'b100;
          else if (edge_q[2]) strobe_d = 3'b010;
          else if (edge_q[1]) strobe_d = 3'b001;

          if (strobe_d != 3'b000) shots_d = shots_dec;
          if (tick)               timer_d = timer_dec;

          // Shot limit and shot clock may both end the turn in one cycle;
          // either way there is exactly one move to SWITCH.
          if (((strobe_d != 3'b000) && (shots_dec == 4'd0)) ||
              (tick && (timer_dec == 8'd0))) begin
            state_d = S_SWITCH;
            timer_d = 8'(SWITCH_TICKS);
          end
        end
      end

      S_SWITCH: begin
        if (win_p1 || win_p2) begin
          state_d  = S_OVER;
          winner_d = win_p1 ? 2'b01 : 2'b10;
        end else if (tick) begin
          timer_d = timer_dec;
          if (timer_dec == 8'd0) begin
            state_d = mode_q ? S_P1 : S_P2;
            mode_d  = ~mode_q;
            timer_d = 8'(SHOT_TIME);
            shots_d = 4'(SHOTS_PER_TURN);
          end
        end
      end

      S_OVER: begin
        if (edge_q[0]) begin
          state_d  = S_IDLE;
          winner_d = 2'b00;
          timer_d  = 8'd0;
          shots_d  = 4'd0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign mode       = mode_q;
  assign shot_one   = strobe_q[0];
  assign shot_two   = strobe_q[1];
  assign shot_three = strobe_q[2];
  assign shot_timer = timer_q;
  assign shots_left = shots_q;
  assign state_code = state_q;
  assign winner     = winner_q;

endmodule
